// File: rtl/imem_encoder_loader.sv
// Encodes symbolic LEGv8 instruction requests and streams them into imem from word 0.
// Optional feature macro: RANGE_CHECK_EN (reject out-of-range LDUR/STUR offsets, flag err).
module imem_encoder_loader #(
  parameter int unsigned IMEM_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [2:0]                    req_kind,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    rn,
  input  logic [4:0]                    rm,
  input  logic [18:0]                   imm,
  output logic                          we,
  output logic [$clog2(IMEM_DEPTH)-1:0] waddr,
  output logic [31:0]                   wdata,
  output logic [$clog2(IMEM_DEPTH):0]   count,
  output logic                          busy,
  output logic                          done,
  output logic                          full,
  output logic                          err
);

  localparam int unsigned ADDR_W = $clog2(IMEM_DEPTH);
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(IMEM_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                full_q, full_d;
  logic [31:0]         enc_word;
  logic                range_bad;
  logic [ADDR_W:0]     count_inc;

  always_comb begin
    unique case (req_kind)
      3'd0:    enc_word = {11'b10001011000, rm, 6'b0, rn, rd};
      3'd1:    enc_word = {11'b11001011000, rm, 6'b0, rn, rd};
      3'd2:    enc_word = {11'b10001010000, rm, 6'b0, rn, rd};
      3'd3:    enc_word = {11'b10101010000, rm, 6'b0, rn, rd};
      3'd4:    enc_word = {8'b10110100, imm, rd};
      3'd5:    enc_word = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      3'd6:    enc_word = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      default: enc_word = 32'h0;
    endcase
  end

`ifdef RANGE_CHECK_EN
  logic err_q, err_d;
  // In range iff bits above the 9-bit field are pure sign extension.
  assign range_bad = ((req_kind == 3'd5) || (req_kind == 3'd6)) &&
                     !((imm[18:8] == 11'h000) || (imm[18:8] == 11'h7ff));
  assign err = err_q;
`else
  assign range_bad = 1'b0;
  assign err       = 1'b0;
`endif

  assign count_inc = count_q + (ADDR_W+1)'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    full_d  = full_q;
`ifdef RANGE_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
          full_d  = 1'b0;
`ifdef RANGE_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (req_valid) begin
          if (req_kind == 3'd7) begin
            state_d = StDone;
          end else if (range_bad) begin
`ifdef RANGE_CHECK_EN
            err_d = 1'b1;
`endif
          end else begin
            // Encode at acceptance so waddr/wdata are stable for the whole EMIT cycle.
            state_d = StEmit;
            waddr_d = count_q[ADDR_W-1:0];
            wdata_d = enc_word;
          end
        end
      end
      StEmit: begin
        count_d = count_inc;
        if (count_inc == DepthCnt) begin
          full_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      full_q  <= 1'b0;
`ifdef RANGE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      full_q  <= full_d;
`ifdef RANGE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Decoded straight from state so an async reset kills the write strobe at once.
  assign req_ready = (state_q == StLoad);
  assign we        = (state_q == StEmit);
  assign busy      = (state_q == StLoad) || (state_q == StEmit);
  assign done      = (state_q == StDone);
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: tb/tb_imem_encoder_loader.sv
// Directed, table-driven bench for imem_encoder_loader (default depth plus a depth-4 instance).
module tb_imem_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, req_valid;
  logic [2:0]  req_kind;
  logic [4:0]  rd, rn, rm;
  logic [18:0] imm;
  logic        req_ready, we, busy, done, full, err;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [6:0]  count;

  logic        s_start, s_req_valid;
  logic        s_req_ready, s_we, s_busy, s_done, s_full, s_err;
  logic [1:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  imem_encoder_loader #(.IMEM_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .we(we), .waddr(waddr),
    .wdata(wdata), .count(count), .busy(busy), .done(done), .full(full), .err(err)
  );

  imem_encoder_loader #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(s_start), .req_valid(s_req_valid),
    .req_ready(s_req_ready), .req_kind(3'd0), .rd(5'd1), .rn(5'd2), .rm(5'd3),
    .imm(19'd0), .we(s_we), .waddr(s_waddr), .wdata(s_wdata), .count(s_count),
    .busy(s_busy), .done(s_done), .full(s_full), .err(s_err)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [18:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_kind = v.kind;
    rd       = v.rd;
    rn       = v.rn;
    rm       = v.rm;
    imm      = v.imm;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Handshake one writing request and check the EMIT cycle and the cycle after it.
  task automatic issue(input vec_t v, input int exp_addr, input string tag);
    @(negedge clk);
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    drive(v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " we"}, {31'b0, we}, 32'd1);
    check({tag, " waddr"}, {26'b0, waddr}, exp_addr);
    check({tag, " wdata"}, wdata, v.exp);
    @(negedge clk);
    check({tag, " we off"}, {31'b0, we}, 32'd0);
    check({tag, " count"}, {25'b0, count}, exp_addr + 1);
    check({tag, " wdata hold"}, wdata, v.exp);
  endtask

  vec_t halt_v, add_v, rng_v;
  int   nwr;

  initial begin
    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  19'd0,      32'h8B030041}; // ADD
    vecs[1] = '{3'd5, 5'd5,  5'd6,  5'd7,  19'd8,      32'hF84080C5}; // LDUR, rm ignored
    vecs[2] = '{3'd6, 5'd1,  5'd2,  5'd0,  19'h7FFFF,  32'hF81FF041}; // STUR imm=-1
    vecs[3] = '{3'd4, 5'd9,  5'd31, 5'd31, 19'h7FFFE,  32'hB4FFFFC9}; // CBZ imm=-2
    vecs[4] = '{3'd1, 5'd4,  5'd5,  5'd6,  19'd0,      32'hCB0600A4}; // SUB
    vecs[5] = '{3'd2, 5'd7,  5'd8,  5'd9,  19'd0,      32'h8A090107}; // AND
    vecs[6] = '{3'd3, 5'd31, 5'd0,  5'd31, 19'd0,      32'hAA1F001F}; // ORR
    halt_v  = '{3'd7, 5'd0, 5'd0, 5'd0, 19'd0, 32'd0};
    add_v   = vecs[0];
    rng_v   = '{3'd5, 5'd0, 5'd0, 5'd0, 19'd256, 32'hF8500000};

    reset = 1'b1; start = 1'b0; req_valid = 1'b0;
    s_start = 1'b0; s_req_valid = 1'b0;
    drive(halt_v);
    repeat (2) @(negedge clk);
    check("rst ready", {31'b0, req_ready}, 32'd0);
    check("rst we", {31'b0, we}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst full", {31'b0, full}, 32'd0);
    check("rst err", {31'b0, err}, 32'd0);
    check("rst count", {25'b0, count}, 32'd0);
    check("rst waddr", {26'b0, waddr}, 32'd0);
    check("rst wdata", wdata, 32'd0);
    reset = 1'b0;

    pulse_start();
    check("start busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 7; i++) issue(vecs[i], i, $sformatf("vec%0d", i));

    @(negedge clk);
    drive(halt_v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("halt we", {31'b0, we}, 32'd0);
    check("halt done", {31'b0, done}, 32'd1);
    check("halt ready", {31'b0, req_ready}, 32'd0);
    check("halt busy", {31'b0, busy}, 32'd0);
    check("halt count", {25'b0, count}, 32'd7);
    check("halt waddr hold", {26'b0, waddr}, 32'd6);
    check("halt full", {31'b0, full}, 32'd0);

    // Restart, then a start pulse while busy must not reset the session.
    pulse_start();
    check("restart done", {31'b0, done}, 32'd0);
    check("restart count", {25'b0, count}, 32'd0);
    issue(add_v, 0, "s2 add");
    pulse_start();
    check("busy start count", {25'b0, count}, 32'd1);
    check("busy start ready", {31'b0, req_ready}, 32'd1);

    @(negedge clk);
    drive(rng_v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef RANGE_CHECK_EN
    check("range we", {31'b0, we}, 32'd0);
    check("range err", {31'b0, err}, 32'd1);
    check("range ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("range count", {25'b0, count}, 32'd1);
    check("range err held", {31'b0, err}, 32'd1);
`else
    check("range we", {31'b0, we}, 32'd1);
    check("range waddr", {26'b0, waddr}, 32'd1);
    check("range wdata", wdata, rng_v.exp);
    check("range imm9", {23'b0, wdata[20:12]}, 32'h100);
    check("range err", {31'b0, err}, 32'd0);
    @(negedge clk);
    check("range count", {25'b0, count}, 32'd2);
`endif
    pulse_start();
    check("ignored start err", {31'b0, busy}, 32'd1);

    // Reset while the write strobe is high.
    @(negedge clk);
    drive(add_v);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre-rst we", {31'b0, we}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid rst we", {31'b0, we}, 32'd0);
    check("mid rst count", {25'b0, count}, 32'd0);
    check("mid rst busy", {31'b0, busy}, 32'd0);
    check("mid rst ready", {31'b0, req_ready}, 32'd0);
    check("mid rst wdata", wdata, 32'd0);
    check("mid rst err", {31'b0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Depth-4 instance: valid held high, memory fills after four words.
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_req_valid = 1'b1;
    nwr = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (s_we) begin
        check($sformatf("d4 waddr%0d", nwr), {30'b0, s_waddr}, nwr);
        check($sformatf("d4 wdata%0d", nwr), s_wdata, 32'h8B030041);
        nwr++;
      end
    end
    s_req_valid = 1'b0;
    check("d4 writes", nwr, 32'd4);
    check("d4 full", {31'b0, s_full}, 32'd1);
    check("d4 done", {31'b0, s_done}, 32'd1);
    check("d4 ready", {31'b0, s_req_ready}, 32'd0);
    check("d4 count", {29'b0, s_count}, 32'd4);
    check("d4 err", {31'b0, s_err}, 32'd0);
    check("d4 busy", {31'b0, s_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
